// File: rtl/grid_ident.sv
// grid_ident: Avalon-MM identification slave.
//
// Word map:
//   0 -> 0,  1 -> ID_WORD0,  2 -> 0,  3 -> ID_WORD1   (legacy close-ID words)
//   4 -> VERSION
//   5 -> SCRATCH (read/write)
//   6 -> UPTIME (read-only)
//   7 -> ACCESS_COUNT in bits 15:0 (read-only, any write clears it)
//
// Handshake contract:
//   A transfer starts when read or write is high. waitrequest is high while
//   a request is present and the ack flag is low. The FSM holds the request
//   for WAIT_STATES cycles. It then spends one ACK cycle with
//   waitrequest low, and the transfer completes in that cycle.
//   readdata is loaded on the edge entering ACK. A write commits on the edge
//   that ends ACK. When read and write are both high, the transfer is a read.
//   Dropping the request during WAIT abandons the transfer with no side
//   effects.
//
// Build option:
//   GRID_IDENT_UPTIME_EN - when defined, a free-running 32-bit uptime counter
//   is built and is readable at word 6. When undefined, no counter exists and
//   word 6 reads 0.
//
// WAIT_STATES must be in 1..15.

module grid_ident #(
  parameter logic [31:0] ID_WORD0    = 32'hA5A5A5A5,
  parameter logic [31:0] ID_WORD1    = 32'h5A5A5A5A,
  parameter logic [31:0] VERSION     = 32'h00010000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ident_address,
  input  logic        avs_ident_read,
  input  logic        avs_ident_write,
  input  logic [31:0] avs_ident_writedata,
  output logic [31:0] avs_ident_readdata,
  output logic        avs_ident_waitrequest
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // With a single wait state the FSM skips WAIT entirely
  localparam logic       WS_ONE  = (WAIT_STATES == 32'd1);
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 32'd1);

  // Register word addresses
  localparam logic [2:0] A_ID0     = 3'd1;
  localparam logic [2:0] A_ID1     = 3'd3;
  localparam logic [2:0] A_VERSION = 3'd4;
  localparam logic [2:0] A_SCRATCH = 3'd5;
  localparam logic [2:0] A_UPTIME  = 3'd6;
  localparam logic [2:0] A_ACCESS  = 3'd7;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_xfer_q, rd_xfer_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] scratch_q, scratch_d;
  logic [15:0] acc_cnt_q, acc_cnt_d;

  logic        req;
  logic        ack;
  logic        enter_ack;
  logic        load_rd;
  logic        wr_commit;
  logic        rd_done;
  logic [31:0] rd_mux;

`ifdef GRID_IDENT_UPTIME_EN
  logic [31:0] uptime_q, uptime_d;
`endif

  assign req       = avs_ident_read | avs_ident_write;
  assign ack       = (state_q == ST_ACK);
  assign enter_ack = (state_d == ST_ACK) & (state_q != ST_ACK);
  // A read wins over a simultaneous write
  assign load_rd   = enter_ack & avs_ident_read;
  assign wr_commit = ack & avs_ident_write & ~rd_xfer_q;
  assign rd_done   = ack & rd_xfer_q;

  assign avs_ident_waitrequest = req & ~ack;
  assign avs_ident_readdata    = readdata_q;

  // Transfer FSM: count wait states, then one ACK cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = 4'd1;
          state_d = WS_ONE ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          // Master abandoned the transfer: drop it without side effects
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WS_LAST) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Remember whether the transfer being acknowledged is a read
  always_comb begin
    rd_xfer_d = rd_xfer_q;
    if (enter_ack) begin
      rd_xfer_d = avs_ident_read;
    end else if (ack) begin
      rd_xfer_d = 1'b0;
    end
  end

  // Read data source selected by the word address
  always_comb begin
    rd_mux = 32'h0;
    case (avs_ident_address)
      A_ID0:     rd_mux = ID_WORD0;
      A_ID1:     rd_mux = ID_WORD1;
      A_VERSION: rd_mux = VERSION;
      A_SCRATCH: rd_mux = scratch_q;
`ifdef GRID_IDENT_UPTIME_EN
      A_UPTIME:  rd_mux = uptime_q;
`else
      A_UPTIME:  rd_mux = 32'h0;
`endif
      A_ACCESS:  rd_mux = {16'h0, acc_cnt_q};
      default:   rd_mux = 32'h0;
    endcase
  end

  // readdata is captured on the edge entering ACK and then held
  always_comb begin
    readdata_d = readdata_q;
    if (load_rd) begin
      readdata_d = rd_mux;
    end
  end

  // Scratch register is written only by a completed write transfer
  always_comb begin
    scratch_d = scratch_q;
    if (wr_commit && (avs_ident_address == A_SCRATCH)) begin
      scratch_d = avs_ident_writedata;
    end
  end

  // Access counter: saturating count of completed reads, cleared by a write
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (wr_commit && (avs_ident_address == A_ACCESS)) begin
      acc_cnt_d = 16'h0;
    end else if (rd_done && (acc_cnt_q != 16'hFFFF)) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
    end
  end

`ifdef GRID_IDENT_UPTIME_EN
  // Uptime counter runs every clock and wraps naturally
  always_comb begin
    uptime_d = uptime_q + 32'd1;
  end

  // Uptime register
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      uptime_q <= 32'h0;
    end else begin
      uptime_q <= uptime_d;
    end
  end
`endif

  // FSM and transfer bookkeeping registers
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rd_xfer_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_xfer_q <= rd_xfer_d;
    end
  end

  // Data registers: readdata, scratch and access count
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      readdata_q <= 32'h0;
      scratch_q  <= 32'h0;
      acc_cnt_q  <= 16'h0;
    end else begin
      readdata_q <= readdata_d;
      scratch_q  <= scratch_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

endmodule

// File: tb/tb_grid_ident.sv
// Testbench for grid_ident.
// Instance 0 is built with WAIT_STATES=1 and instance 1 with WAIT_STATES=4.
// Both instances share the clock and reset.
// Define GRID_IDENT_UPTIME_EN to also exercise the uptime word.

module tb_grid_ident;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        wreq  [2];

  int          ws_exp [2];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          sel;
    logic        r;
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  grid_ident #(.WAIT_STATES(1)) u_dut1 (
    .csi_MCLK_clk          (clk),
    .rsi_MRST_reset        (rst),
    .avs_ident_address     (addr[0]),
    .avs_ident_read        (rd[0]),
    .avs_ident_write       (wr[0]),
    .avs_ident_writedata   (wdata[0]),
    .avs_ident_readdata    (rdata[0]),
    .avs_ident_waitrequest (wreq[0])
  );

  grid_ident #(.WAIT_STATES(4)) u_dut4 (
    .csi_MCLK_clk          (clk),
    .rsi_MRST_reset        (rst),
    .avs_ident_address     (addr[1]),
    .avs_ident_read        (rd[1]),
    .avs_ident_write       (wr[1]),
    .avs_ident_writedata   (wdata[1]),
    .avs_ident_readdata    (rdata[1]),
    .avs_ident_waitrequest (wreq[1])
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // comparison helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one complete transfer, returns readdata seen in the ACK cycle
  task automatic xfer(input int sel, input logic r, input logic w, input logic [2:0] a,
                      input logic [31:0] d, output logic [31:0] q, output int ws_cnt,
                      output int ack_cyc);
    @(negedge clk);
    addr[sel]  = a;
    rd[sel]    = r;
    wr[sel]    = w;
    wdata[sel] = d;
    #1;
    ws_cnt = 0;
    while (wreq[sel] && ws_cnt < 40) begin
      ws_cnt++;
      @(negedge clk);
      #1;
    end
    if (wreq[sel]) begin
      errors++;
      $display("FAIL xfer_timeout sel %0d addr %0d waitrequest still high", sel, a);
    end
    q       = rdata[sel];
    ack_cyc = cyc;
    @(negedge clk);
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
  endtask

  // driver + scoreboard: read and compare against queued expectation
  task automatic read_chk(input int sel, input logic [2:0] a, input logic [31:0] exp,
                          input string name);
    logic [31:0] q;
    int          ws;
    int          c;
    exp_q.push_back(exp);
    xfer(sel, 1'b1, 1'b0, a, 32'h0, q, ws, c);
    chk(name, q, exp_q.pop_front());
  endtask

  task automatic write_do(input int sel, input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    int          ws;
    int          c;
    xfer(sel, 1'b0, 1'b1, a, d, q, ws, c);
  endtask

  // driver: request that is abandoned while in WAIT
  task automatic drop_req(input int sel, input logic r, input logic w, input logic [2:0] a,
                          input logic [31:0] d);
    @(negedge clk);
    addr[sel]  = a;
    rd[sel]    = r;
    wr[sel]    = w;
    wdata[sel] = d;
    repeat (2) @(negedge clk);
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] q, qa, qb;
    int          ws, ca, cb, c_rel;

    ws_exp[0] = 1;
    ws_exp[1] = 4;
    for (int s = 0; s < 2; s++) begin
      addr[s]  = 3'd0;
      rd[s]    = 1'b0;
      wr[s]    = 1'b0;
      wdata[s] = 32'h0;
    end

    // sel, r, w, addr, wdata, expected readdata (reads only)
    vecs.push_back('{0, 1'b1, 1'b0, 3'd0, 32'h0,        32'h00000000});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd1, 32'h0,        32'hA5A5A5A5});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd2, 32'h0,        32'h00000000});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd3, 32'h0,        32'h5A5A5A5A});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd4, 32'h0,        32'h00010000});
    vecs.push_back('{0, 1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd5, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{0, 1'b0, 1'b1, 3'd1, 32'h12345678, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd1, 32'h0,        32'hA5A5A5A5});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd7, 32'h0,        32'h00000007});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd7, 32'h0,        32'h00000008});
    vecs.push_back('{0, 1'b0, 1'b1, 3'd7, 32'h0,        32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd7, 32'h0,        32'h00000000});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd0, 32'h0,        32'h00000000});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd0, 32'h0,        32'h00000000});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd7, 32'h0,        32'h00000003});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd7, 32'h0,        32'h00000004});
    vecs.push_back('{0, 1'b1, 1'b1, 3'd5, 32'h11111111, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd5, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{0, 1'b0, 1'b1, 3'd6, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd0, 32'h0,        32'h00000000});
    vecs.push_back('{0, 1'b0, 1'b1, 3'd2, 32'h00000055, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd2, 32'h0,        32'h00000000});
    vecs.push_back('{0, 1'b1, 1'b0, 3'd7, 32'h0,        32'h00000009});
    vecs.push_back('{1, 1'b1, 1'b0, 3'd4, 32'h0,        32'h00010000});
    vecs.push_back('{1, 1'b1, 1'b0, 3'd1, 32'h0,        32'hA5A5A5A5});
    vecs.push_back('{1, 1'b0, 1'b1, 3'd5, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{1, 1'b1, 1'b0, 3'd5, 32'h0,        32'hCAFEF00D});
    vecs.push_back('{1, 1'b1, 1'b0, 3'd7, 32'h0,        32'h00000003});

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_rdata0", rdata[0], 32'h0);
    chk("reset_rdata1", rdata[1], 32'h0);
    chk("reset_wreq0", {31'h0, wreq[0]}, 32'h0);
    chk("reset_wreq1", {31'h0, wreq[1]}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].r) exp_q.push_back(vecs[i].exp);
      xfer(vecs[i].sel, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, q, ws, ca);
      chk($sformatf("vec%0d_waitcycles", i), 32'(ws), 32'(ws_exp[vecs[i].sel]));
      if (vecs[i].r) chk($sformatf("vec%0d_rdata", i), q, exp_q.pop_front());
    end

    // abandoned transfers in WAIT leave no trace (instance 1, count is 4)
    drop_req(1, 1'b1, 1'b0, 3'd0, 32'h0);
    chk("drop_rd_hold", rdata[1], 32'h00000003);
    drop_req(1, 1'b0, 1'b1, 3'd5, 32'h0BAD0BAD);
    read_chk(1, 3'd5, 32'hCAFEF00D, "drop_wr_scratch");
    read_chk(1, 3'd7, 32'h00000005, "drop_count");

    // access count saturation (instance 0)
    force u_dut1.acc_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_dut1.acc_cnt_q;
    read_chk(0, 3'd0, 32'h0, "sat_pre");
    read_chk(0, 3'd7, 32'h0000FFFF, "sat_a");
    read_chk(0, 3'd7, 32'h0000FFFF, "sat_b");

`ifdef GRID_IDENT_UPTIME_EN
    xfer(0, 1'b1, 1'b0, 3'd6, 32'h0, qa, ws, ca);
    repeat (10) @(negedge clk);
    xfer(0, 1'b1, 1'b0, 3'd6, 32'h0, qb, ws, cb);
    chk("uptime_delta", qb - qa, 32'(cb - ca));
    force u_dut1.uptime_q = 32'hFFFFFFF0;
    @(negedge clk);
    release u_dut1.uptime_q;
    c_rel = cyc;
    repeat (30) @(negedge clk);
    xfer(0, 1'b1, 1'b0, 3'd6, 32'h0, q, ws, cb);
    chk("uptime_wrap", q, 32'hFFFFFFF0 + 32'(cb - c_rel - 1));
`else
    qa = 32'h0;
    qb = 32'h0;
    ca = 0;
    cb = 0;
    c_rel = 0;
    read_chk(0, 3'd6, 32'h0, "uptime_absent");
    read_chk(1, 3'd6, 32'h0, "uptime_absent_ws4");
`endif

    // reset asserted during WAIT of a write to scratch (instance 1)
    @(negedge clk);
    addr[1]  = 3'd5;
    wr[1]    = 1'b1;
    wdata[1] = 32'h0BADF00D;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr[1] = 1'b0;
    #1;
    chk("rst_mid_wreq", {31'h0, wreq[1]}, 32'h0);
    chk("rst_mid_rdata", rdata[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    read_chk(1, 3'd5, 32'h0, "rst_mid_scratch");
    read_chk(0, 3'd7, 32'h0, "rst_mid_count");
    read_chk(0, 3'd5, 32'h0, "rst_scratch0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
